// File: rtl/channel_sample_scheduler_if.sv
// Buffer RAM port and readout sample stream of channel_sample_scheduler.
interface channel_sample_scheduler_if #(
  parameter int DW = 8,
  parameter int AW = 7
);
  logic          buf_we;
  logic          buf_re;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_wdata;
  logic [DW-1:0] buf_rdata;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready;

  modport master (
    output buf_we, buf_re, buf_addr, buf_wdata,
    input  buf_rdata,
    output rd_valid, rd_data,
    input  rd_ready
  );

  modport slave (
    input  buf_we, buf_re, buf_addr, buf_wdata,
    output buf_rdata,
    input  rd_valid, rd_data,
    output rd_ready
  );
endinterface

// File: rtl/channel_sample_scheduler.sv
// Round-robin arbiter between N_CH capture channels and one readout engine over a shared
// single-port sample buffer. Define CHSCHED_DROP_NEW_EN to discard captures into full channels.
module channel_sample_scheduler #(
  parameter int N_CH  = 7,
  parameter int DEPTH = 10,
  parameter int DW    = 8,
  parameter int AW    = $clog2(N_CH * DEPTH),
  parameter int CW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [N_CH-1:0]    cap_req,
  input  logic [N_CH*DW-1:0] cap_data,
  output logic [N_CH-1:0]    cap_gnt,
  input  logic               rd_start,
  input  logic [CW-1:0]      rd_ch,
  output logic               rd_busy,
  output logic               rd_done,
  output logic [N_CH-1:0]    ovf,
  output logic [0:0]         dbg_state,
  channel_sample_scheduler_if.master bus
);

  localparam int NS  = N_CH + 1;
  localparam int SW  = $clog2(NS);
  localparam int PW  = $clog2(DEPTH);
  localparam int CNW = $clog2(DEPTH + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

`ifdef CHSCHED_DROP_NEW_EN
  localparam bit DROP_NEW = 1'b1;
`else
  localparam bit DROP_NEW = 1'b0;
`endif

  logic [PW-1:0]  wptr  [N_CH];
  logic [PW-1:0]  rptr  [N_CH];
  logic [CNW-1:0] count [N_CH];
  logic [DW-1:0]  sample [N_CH];
  logic [SW-1:0]  rr_ptr;
  logic [0:0]     state;
  logic [CW-1:0]  cur_ch;
  logic [CNW-1:0] remaining;
  logic           pending;

  logic           rd_req;
  logic [NS-1:0]  req;
  logic [NS-1:0]  req_rot;
  logic           win_valid;
  logic [SW-1:0]  win;
  logic           cap_fire;
  logic           rd_fire;
  logic [CW-1:0]  cap_ch;
  logic           cap_full;
  logic           cap_write;
  logic           start_fire;
  logic           drain_end;

  function automatic logic [AW-1:0] addr_of(input logic [CW-1:0] ch, input logic [PW-1:0] ptr);
    return AW'(int'(ch) * DEPTH + int'(ptr));
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    for (int c = 0; c < N_CH; c++) sample[c] = cap_data[c*DW +: DW];
  end

  // Readout stream: a sample moves on every rising edge where rd_valid && rd_ready; rd_data
  // is held stable while rd_valid is high and rd_ready is low. At most one read is in flight,
  // and a read is only issued when the output register is empty or being emptied this cycle.
  assign rd_req = (state == ST_DRAIN) && (remaining != '0) && !pending &&
                  (!bus.rd_valid || bus.rd_ready);
  assign req    = {rd_req, cap_req};

  always_comb begin
    req_rot   = NS'({req, req} >> rr_ptr);
    win_valid = 1'b0;
    win       = '0;
    for (int k = 0; k < NS; k++) begin
      if (!win_valid && req_rot[k]) begin
        win_valid = 1'b1;
        win = (int'(rr_ptr) + k >= NS) ? SW'(int'(rr_ptr) + k - NS) : SW'(int'(rr_ptr) + k);
      end
    end
    if (!ena) win_valid = 1'b0;
  end

  assign cap_fire   = win_valid && (win != SW'(N_CH));
  assign rd_fire    = win_valid && (win == SW'(N_CH));
  assign cap_ch     = CW'(win);
  assign cap_full   = (count[cap_ch] == CNW'(DEPTH));
  assign cap_write  = cap_fire && (!cap_full || !DROP_NEW);
  assign start_fire = ena && rd_start && (state == ST_IDLE);
  assign drain_end  = (state == ST_DRAIN) && (remaining == '0) && !pending &&
                      bus.rd_valid && bus.rd_ready;

  always_comb begin
    cap_gnt = '0;
    if (cap_fire) cap_gnt[cap_ch] = 1'b1;
  end

  assign rd_busy   = (state == ST_DRAIN);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        wptr[c]  <= '0;
        rptr[c]  <= '0;
        count[c] <= '0;
      end
      rr_ptr        <= '0;
      state         <= ST_IDLE;
      cur_ch        <= '0;
      remaining     <= '0;
      pending       <= 1'b0;
      rd_done       <= 1'b0;
      ovf           <= '0;
      bus.buf_we    <= 1'b0;
      bus.buf_re    <= 1'b0;
      bus.buf_addr  <= '0;
      bus.buf_wdata <= '0;
      bus.rd_valid  <= 1'b0;
      bus.rd_data   <= '0;
    end else begin
      bus.buf_we <= 1'b0;
      bus.buf_re <= 1'b0;
      rd_done    <= 1'b0;

      if (win_valid) rr_ptr <= (win == SW'(N_CH)) ? '0 : win + SW'(1);

      if (start_fire) begin
        cur_ch     <= rd_ch;
        remaining  <= count[rd_ch];
        ovf[rd_ch] <= 1'b0;
        if (count[rd_ch] == '0) rd_done <= 1'b1;
        else                    state   <= ST_DRAIN;
      end else if (drain_end) begin
        state   <= ST_IDLE;
        rd_done <= 1'b1;
      end

      // A full channel keeps its count: the oldest sample is overwritten (or the new one dropped).
      if (cap_write) begin
        bus.buf_we    <= 1'b1;
        bus.buf_addr  <= addr_of(cap_ch, wptr[cap_ch]);
        bus.buf_wdata <= sample[cap_ch];
        wptr[cap_ch]  <= ptr_inc(wptr[cap_ch]);
        if (cap_full) rptr[cap_ch]  <= ptr_inc(rptr[cap_ch]);
        else          count[cap_ch] <= count[cap_ch] + CNW'(1);
      end
      if (cap_fire && cap_full) ovf[cap_ch] <= 1'b1;

      if (rd_fire) begin
        bus.buf_re     <= 1'b1;
        bus.buf_addr   <= addr_of(cur_ch, rptr[cur_ch]);
        rptr[cur_ch]   <= ptr_inc(rptr[cur_ch]);
        count[cur_ch]  <= count[cur_ch] - CNW'(1);
        remaining      <= remaining - CNW'(1);
        pending        <= 1'b1;
      end

      if (pending) begin
        bus.rd_data  <= bus.buf_rdata;
        bus.rd_valid <= 1'b1;
        pending      <= 1'b0;
      end else if (bus.rd_valid && bus.rd_ready) begin
        bus.rd_valid <= 1'b0;
      end
    end
  end

endmodule
